acs_unit: RTL and testbench
===========================

Name: acs_unit

Overview:
- Add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder (generators 7,5 octal; 4 trellis states).
- Accepts one received symbol per handshake, then walks the 4 next-states serially, one per cycle.
- Emits the new path metric, survivor decision, state address, termination flag and data_id each cycle, directly into the PM_mem pipeline register.
- Holds the current path-metric set internally and commits it after each symbol.

Parameters:
- INIT_PM, 7'd32, initial metric of states 1..3 at frame start (state 0 starts at 0).
- NORM_TH, 7'd64, normalization threshold and subtrahend (only used with ACS_NORM_EN).

Ports:
- PM_clk  in  1  clock.
- PM_rst  in  1  reset, asynchronous, active-low.
- sym_valid  in  1  symbol offered.
- sym_ready  out  1  block can accept a symbol.
- sym_in  in  2  received bits {c0,c1}; c0 is the g=7 output, c1 is the g=5 output.
- sym_first  in  1  first symbol of frame; reinitialize metrics before use.
- sym_term  in  1  tail symbol; only input u=0 is legal.
- data_id  in  3  frame tag, latched with the symbol.
- PM_out  out  7  new path metric of state addr_out.
- dec_out  out  1  survivor bit, i.e. the LSB of the chosen predecessor.
- addr_out  out  2  next-state index.
- term_out  out  1  tail-symbol flag.
- data_id_out  out  3  latched tag.
- out_valid  out  1  PM_out/dec_out/addr_out are meaningful this cycle.

Behaviour:
- State index = {s1,s0}.
- Trellis: next state ns = {u, p1}. Predecessors of ns are p = {p1,x}, x in {0,1}.
- Branch output from p with input u: c0 = u^p1^x, c1 = u^x.
- Branch metric = Hamming distance (0..2) between {c0,c1} and sym_in.
- Candidates: PM[p] + BM, saturating at 127.
- Select the smaller candidate; on a tie select x=0. dec_out = selected x.
- FSM:
  - IDLE: sym_ready=1. On sym_valid, latch sym_in, sym_term, data_id. If sym_first=1, load PM = {0, INIT_PM, INIT_PM, INIT_PM} before computing. Go to CALC with cnt=0.
  - CALC: sym_ready=0. Each cycle compute state ns=cnt and write the result into shadow register NPM[cnt]. On cnt=3, copy NPM into PM (normalized if enabled) and go to IDLE.
- Output timing:
  - Outputs are registered; the result for cnt=k appears on the following clock edge, with out_valid=1.
  - Latency from accept to addr 0 output is 2 edges. Throughput is 1 symbol per 5 cycles.
  - addr_out sequence per symbol is always 0,1,2,3.
- Termination: if the latched sym_term=1, states with ns[1]=1 output PM=127 and dec=0, and 127 is committed for them.
- Idle values (out_valid=0): PM_out, dec_out and addr_out hold their last value; term_out=1; data_id_out holds.
- Reset values: PM_out=0, dec_out=0, addr_out=0, term_out=1, data_id_out=0, out_valid=0, sym_ready=1.
- Reset state: FSM=IDLE, PM={0, INIT_PM, INIT_PM, INIT_PM}.
- Reset mid-CALC aborts the symbol; no partial commit survives.
- A symbol is accepted only in IDLE. sym_valid during CALC is ignored, with no loss because sym_ready=0.

Optional Feature:
- ACS_NORM_EN defined: at commit, if all four NPM >= NORM_TH, subtract NORM_TH from each before storing. Emitted PM_out values are un-normalized; normalization is visible from the next symbol onward.
- Not defined: no normalization; saturation at 127 only.

Decomposition:
- Package acs_pkg holds:
  - constants N_STATES=4, PM_W=7, PM_MAX=7'd127;
  - the FSM state typedef (IDLE, CALC);
  - a function for branch outputs {c0,c1} given (p,u).
- One natural sub-module: acs_butterfly_cell. It is combinational (two saturating adders plus compare/select, tie to x=0), instantiated once and time-shared over cnt.

Test Plan:
- Reset, then sym_first=1 with sym_in=00 -> addr 0..3 gives PM 0,33,2,33; dec 0,0,0,0; out_valid high for 4 cycles; sym_ready low for 4 cycles.
- Same first symbol with sym_term=1 -> PM 0,33,127,127; term_out=1 on all four outputs, and 1 again when idle.
- Two symbols 11 then 10 with sym_first on the first -> check each PM/dec against a bench reference model. Check a tie resolves to dec=0.
- Assert PM_rst mid-CALC (after addr 1) -> outputs return to reset values; the next sym_first symbol reproduces scenario 1 exactly.
- 60 random symbols without sym_first and with ACS_NORM_EN -> no committed PM >= 127 except term-forced states; each normalization event lowers all four stored metrics by exactly 64.
- Hold sym_valid high continuously -> a symbol is accepted every 5 cycles; data_id_out follows each tag with no skipped or duplicated symbol.

Source files
------------

// File: rtl/acs_pkg.sv
// -----------------------------------------------------------------------------
// acs_pkg
// Shared definitions for the add-compare-select stage of the K=3, rate-1/2
// hard-decision Viterbi decoder (generators 7,5 octal, 4 trellis states).
//   - Path-metric width and saturation value.
//   - FSM state encoding used by acs_unit.
//   - Branch output and branch metric helpers.
// -----------------------------------------------------------------------------
package acs_pkg;

  localparam int              N_STATES = 4;
  localparam int              PM_W     = 7;
  localparam logic [PM_W-1:0] PM_MAX   = 7'd127;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } acs_state_e;

  // Encoder output {c0,c1} when input u leaves predecessor state p = {p1,x}.
  // c0 comes from generator 7 (u^p1^x), c1 from generator 5 (u^x).
  function automatic logic [1:0] branch_out(input logic [1:0] p, input logic u);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/acs_butterfly_cell.sv
// -----------------------------------------------------------------------------
// acs_butterfly_cell
// Combinational add-compare-select for one next-state: adds the branch metric
// to each of the two predecessor metrics with saturation at PM_MAX and keeps
// the smaller sum. A tie selects the x=0 predecessor.
// Ports:
//   pm_x0_i / pm_x1_i  metrics of predecessors {p1,0} and {p1,1}
//   bm_x0_i / bm_x1_i  branch metrics of the two transitions
//   pm_o               selected (survivor) metric
//   dec_o              selected x (LSB of the surviving predecessor)
// -----------------------------------------------------------------------------
module acs_butterfly_cell
  import acs_pkg::*;
(
  input  logic [PM_W-1:0] pm_x0_i,
  input  logic [PM_W-1:0] pm_x1_i,
  input  logic [1:0]      bm_x0_i,
  input  logic [1:0]      bm_x1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W:0]   sum_x0;
  logic [PM_W:0]   sum_x1;
  logic [PM_W-1:0] cand_x0;
  logic [PM_W-1:0] cand_x1;

  // One extra bit catches the carry; any carry means the sum exceeded PM_MAX.
  assign sum_x0  = {1'b0, pm_x0_i} + {{(PM_W-1){1'b0}}, bm_x0_i};
  assign sum_x1  = {1'b0, pm_x1_i} + {{(PM_W-1){1'b0}}, bm_x1_i};
  assign cand_x0 = sum_x0[PM_W] ? PM_MAX : sum_x0[PM_W-1:0];
  assign cand_x1 = sum_x1[PM_W] ? PM_MAX : sum_x1[PM_W-1:0];

  // Strict compare so equal candidates keep the x=0 path.
  assign dec_o = (cand_x1 < cand_x0);
  assign pm_o  = dec_o ? cand_x1 : cand_x0;

endmodule

// File: rtl/acs_unit.sv
// -----------------------------------------------------------------------------
// acs_unit
// Add-compare-select stage. Accepts one received symbol per handshake, then
// evaluates next-states 0..3 serially (one per cycle) through a single shared
// acs_butterfly_cell, emitting registered results into the PM_mem pipeline.
// The new metric set is committed to the internal path-metric store after the
// fourth state.
// Ports:
//   PM_clk, PM_rst           clock; asynchronous active-low reset
//   sym_valid / sym_ready    symbol handshake (accepted only when idle)
//   sym_in                   received {c0,c1}
//   sym_first                reload the initial metric set before this symbol
//   sym_term                 tail symbol: states with ns[1]=1 forced to PM_MAX
//   data_id                  frame tag latched with the symbol
//   PM_out, dec_out,
//   addr_out, term_out,
//   data_id_out, out_valid   registered per-state results
// Build option: define ACS_NORM_EN to subtract NORM_TH from all committed
// metrics when every one of them has reached NORM_TH.
// -----------------------------------------------------------------------------
module acs_unit
  import acs_pkg::*;
#(
  parameter logic [PM_W-1:0] INIT_PM = 7'd32
`ifdef ACS_NORM_EN
  , parameter logic [PM_W-1:0] NORM_TH = 7'd64
`endif
) (
  input  logic            PM_clk,
  input  logic            PM_rst,
  input  logic            sym_valid,
  output logic            sym_ready,
  input  logic [1:0]      sym_in,
  input  logic            sym_first,
  input  logic            sym_term,
  input  logic [2:0]      data_id,
  output logic [PM_W-1:0] PM_out,
  output logic            dec_out,
  output logic [1:0]      addr_out,
  output logic            term_out,
  output logic [2:0]      data_id_out,
  output logic            out_valid
);

  acs_state_e      state_q, state_d;
  logic [1:0]      cnt_q;
  logic [1:0]      sym_q;
  logic            term_q;
  logic [2:0]      id_q;
  logic [PM_W-1:0] pm_q   [N_STATES];
  logic [PM_W-1:0] npm_q  [N_STATES-1];
  logic [PM_W-1:0] npm_all[N_STATES];
  logic [PM_W-1:0] commit_pm[N_STATES];

  logic [PM_W-1:0] pm_out_q;
  logic            dec_out_q;
  logic [1:0]      addr_out_q;
  logic            term_out_q;
  logic [2:0]      id_out_q;
  logic            out_valid_q;

  // ---------------------------------------------------------------------------
  // Datapath for next-state ns = cnt_q = {u, p1}
  // ---------------------------------------------------------------------------
  logic [1:0]      pred_x0, pred_x1;
  logic [1:0]      bm_x0, bm_x1;
  logic [PM_W-1:0] cell_pm, res_pm;
  logic            cell_dec, res_dec;

  assign pred_x0 = {cnt_q[0], 1'b0};
  assign pred_x1 = {cnt_q[0], 1'b1};
  assign bm_x0   = hamming2(branch_out(pred_x0, cnt_q[1]), sym_q);
  assign bm_x1   = hamming2(branch_out(pred_x1, cnt_q[1]), sym_q);

  acs_butterfly_cell u_cell (
    .pm_x0_i (pm_q[pred_x0]),
    .pm_x1_i (pm_q[pred_x1]),
    .bm_x0_i (bm_x0),
    .bm_x1_i (bm_x1),
    .pm_o    (cell_pm),
    .dec_o   (cell_dec)
  );

  // A tail symbol only allows u=0, so states reached with u=1 are unreachable.
  assign res_pm  = (term_q && cnt_q[1]) ? PM_MAX : cell_pm;
  assign res_dec = (term_q && cnt_q[1]) ? 1'b0   : cell_dec;

  // State 3 is committed straight from the datapath in the same cycle it is
  // computed, so only states 0..2 need shadow storage.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    for (int i = 0; i < N_STATES - 1; i++) npm_all[i] = npm_q[i];
    npm_all[N_STATES-1] = res_pm;
    commit_pm = npm_all;
`ifdef ACS_NORM_EN
    if ((npm_all[0] >= NORM_TH) && (npm_all[1] >= NORM_TH) &&
        (npm_all[2] >= NORM_TH) && (npm_all[3] >= NORM_TH)) begin
      for (int i = 0; i < N_STATES; i++) commit_pm[i] = npm_all[i] - NORM_TH;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sym_valid)       state_d = CALC;
      CALC:    if (cnt_q == 2'd3)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign sym_ready = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      sym_q       <= 2'd0;
      term_q      <= 1'b0;
      id_q        <= 3'd0;
      pm_q        <= '{{PM_W{1'b0}}, INIT_PM, INIT_PM, INIT_PM};
      pm_out_q    <= '0;
      dec_out_q   <= 1'b0;
      addr_out_q  <= 2'd0;
      term_out_q  <= 1'b1;
      id_out_q    <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == CALC);
      if (state_q == IDLE) begin
        term_out_q <= 1'b1;
        if (sym_valid) begin
          sym_q  <= sym_in;
          term_q <= sym_term;
          id_q   <= data_id;
          cnt_q  <= 2'd0;
          if (sym_first) pm_q <= '{{PM_W{1'b0}}, INIT_PM, INIT_PM, INIT_PM};
        end
      end else begin
        cnt_q      <= cnt_q + 2'd1;
        pm_out_q   <= res_pm;
        dec_out_q  <= res_dec;
        addr_out_q <= cnt_q;
        term_out_q <= term_q;
        id_out_q   <= id_q;
        if (cnt_q == 2'd3) pm_q <= commit_pm;
      end
    end
  end

  // NOTE: the shadow metrics carry no reset; each entry is rewritten in the
  // same symbol before it is read at commit, and an aborted symbol never commits.
  always_ff @(posedge PM_clk) begin
    if (state_q == CALC) begin
      for (int i = 0; i < N_STATES - 1; i++) begin
        if (cnt_q == 2'(i)) npm_q[i] <= res_pm;
      end
    end
  end

  assign PM_out      = pm_out_q;
  assign dec_out     = dec_out_q;
  assign addr_out    = addr_out_q;
  assign term_out    = term_out_q;
  assign data_id_out = id_out_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_acs_unit.sv
// -----------------------------------------------------------------------------
// tb_acs_unit
// Directed self-checking bench for acs_unit. Expected metrics for the directed
// symbols are hand-derived from the 7,5 trellis; the random section uses a
// forward-iterating trellis model (with normalization when ACS_NORM_EN is set).
// -----------------------------------------------------------------------------
module tb_acs_unit;

  logic       PM_clk = 1'b0;
  logic       PM_rst;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym_in;
  logic       sym_first;
  logic       sym_term;
  logic [2:0] data_id;
  logic [6:0] PM_out;
  logic       dec_out;
  logic [1:0] addr_out;
  logic       term_out;
  logic [2:0] data_id_out;
  logic       out_valid;

  acs_unit dut (
    .PM_clk      (PM_clk),
    .PM_rst      (PM_rst),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_in      (sym_in),
    .sym_first   (sym_first),
    .sym_term    (sym_term),
    .data_id     (data_id),
    .PM_out      (PM_out),
    .dec_out     (dec_out),
    .addr_out    (addr_out),
    .term_out    (term_out),
    .data_id_out (data_id_out),
    .out_valid   (out_valid)
  );

  always #5 PM_clk = ~PM_clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] got_pm   [4];
  logic       got_dec  [4];
  logic [1:0] got_addr [4];
  logic       got_term [4];
  logic [2:0] got_id   [4];
  logic       got_valid[4];
  logic       got_ready[4];

  int model_pm[4];
  int exp_pm  [4];
  int exp_dec [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Forward trellis walk: every (state, input) pair proposes a candidate for
  // its successor; ascending p visits the x=0 predecessor first, so a strict
  // less-than keeps x=0 on ties.
  task automatic model_step(input logic [1:0] s, input logic t);
    int nxt[4];
    int all_hi;
    for (int i = 0; i < 4; i++) begin
      exp_pm[i]  = 1000;
      exp_dec[i] = 0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        int ns, x, c0, c1, bm, cand;
        x    = p % 2;
        ns   = 2 * u + p / 2;
        c0   = u ^ (p / 2) ^ x;
        c1   = u ^ x;
        bm   = ((c0 != s[1]) ? 1 : 0) + ((c1 != s[0]) ? 1 : 0);
        cand = model_pm[p] + bm;
        if (cand > 127) cand = 127;
        if (cand < exp_pm[ns]) begin
          exp_pm[ns]  = cand;
          exp_dec[ns] = x;
        end
      end
    end
    if (t) begin
      exp_pm[2] = 127; exp_dec[2] = 0;
      exp_pm[3] = 127; exp_dec[3] = 0;
    end
    for (int i = 0; i < 4; i++) nxt[i] = exp_pm[i];
`ifdef ACS_NORM_EN
    all_hi = 1;
    for (int i = 0; i < 4; i++) if (nxt[i] < 64) all_hi = 0;
    if (all_hi != 0) for (int i = 0; i < 4; i++) nxt[i] = nxt[i] - 64;
`else
    all_hi = 0;
`endif
    for (int i = 0; i < 4; i++) model_pm[i] = nxt[i];
  endtask

  // Offers one symbol in IDLE and captures the four result cycles.
  task automatic run_symbol(input logic [1:0] s, input logic f, input logic t,
                            input logic [2:0] id);
    @(negedge PM_clk);
    chk("ready_before_accept", sym_ready, 1);
    sym_valid = 1'b1; sym_in = s; sym_first = f; sym_term = t; data_id = id;
    @(negedge PM_clk);
    sym_valid = 1'b0; sym_first = 1'b0; sym_term = 1'b0;
    chk("ready_low_after_accept", sym_ready, 0);
    chk("valid_low_after_accept", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge PM_clk);
      got_pm[k]    = PM_out;
      got_dec[k]   = dec_out;
      got_addr[k]  = addr_out;
      got_term[k]  = term_out;
      got_id[k]    = data_id_out;
      got_valid[k] = out_valid;
      got_ready[k] = sym_ready;
    end
  endtask

  task automatic check_frame(input string tag, input int e_pm[4], input int e_dec[4],
                             input logic e_term, input logic [2:0] e_id);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_pm%0d", tag, k),    got_pm[k],    e_pm[k]);
      chk($sformatf("%s_dec%0d", tag, k),   got_dec[k],   e_dec[k]);
      chk($sformatf("%s_addr%0d", tag, k),  got_addr[k],  k);
      chk($sformatf("%s_valid%0d", tag, k), got_valid[k], 1);
      chk($sformatf("%s_term%0d", tag, k),  got_term[k],  e_term);
      chk($sformatf("%s_id%0d", tag, k),    got_id[k],    e_id);
      chk($sformatf("%s_ready%0d", tag, k), got_ready[k], (k == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int         zero4[4];
    int         one4[4];
    logic [2:0] tags[4];
    logic [2:0] rec_id[8];
    int         rec_cyc[8];
    int         n_rec;
    int         idx;
    logic [1:0] rs;
    logic       rt;
    logic [2:0] rid;

    zero4 = '{0, 0, 0, 0};
    one4  = '{1, 1, 1, 1};

    // Reset values
    PM_rst = 1'b0; sym_valid = 1'b0; sym_in = 2'b00; sym_first = 1'b0;
    sym_term = 1'b0; data_id = 3'd0;
    repeat (2) @(negedge PM_clk);
    chk("rst_pm", PM_out, 0);
    chk("rst_dec", dec_out, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_term", term_out, 1);
    chk("rst_id", data_id_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", sym_ready, 1);
    PM_rst = 1'b1;

    // Scenario 1: first symbol 00
    run_symbol(2'b00, 1'b1, 1'b0, 3'd2);
    check_frame("s1", '{0, 33, 2, 33}, zero4, 1'b0, 3'd2);
    @(negedge PM_clk);
    chk("s1_idle_valid", out_valid, 0);
    chk("s1_idle_term", term_out, 1);
    chk("s1_idle_pm_hold", PM_out, 33);
    chk("s1_idle_addr_hold", addr_out, 3);
    chk("s1_idle_id_hold", data_id_out, 2);

    // Scenario 2: first symbol 00 as a tail symbol
    run_symbol(2'b00, 1'b1, 1'b1, 3'd3);
    check_frame("s2", '{0, 33, 127, 127}, zero4, 1'b1, 3'd3);
    @(negedge PM_clk);
    chk("s2_idle_term", term_out, 1);
    chk("s2_idle_valid", out_valid, 0);

    // Scenario 3: 11 (first), 10, 00; ties at states 1/3 of the first symbol
    run_symbol(2'b11, 1'b1, 1'b0, 3'd4);
    check_frame("s3a", '{2, 33, 0, 33}, zero4, 1'b0, 3'd4);
    chk("s3a_tie_dec", got_dec[1], 0);
    run_symbol(2'b10, 1'b0, 1'b0, 3'd5);
    check_frame("s3b", '{3, 0, 3, 2}, zero4, 1'b0, 3'd5);
    run_symbol(2'b00, 1'b0, 1'b0, 3'd6);
    check_frame("s3c", '{2, 3, 0, 3}, one4, 1'b0, 3'd6);

    // Scenario 4: reset after the addr 1 output
    @(negedge PM_clk);
    sym_valid = 1'b1; sym_in = 2'b01; sym_first = 1'b0; data_id = 3'd7;
    @(negedge PM_clk);
    sym_valid = 1'b0;
    @(negedge PM_clk);
    @(negedge PM_clk);
    chk("s4_pre_addr", addr_out, 1);
    chk("s4_pre_valid", out_valid, 1);
    #2 PM_rst = 1'b0;
    #1;
    chk("s4_rst_pm", PM_out, 0);
    chk("s4_rst_dec", dec_out, 0);
    chk("s4_rst_addr", addr_out, 0);
    chk("s4_rst_term", term_out, 1);
    chk("s4_rst_id", data_id_out, 0);
    chk("s4_rst_valid", out_valid, 0);
    chk("s4_rst_ready", sym_ready, 1);
    @(negedge PM_clk);
    PM_rst = 1'b1;
    // Without sym_first the metrics must already be the reset set.
    run_symbol(2'b00, 1'b0, 1'b0, 3'd1);
    check_frame("s4_norst", '{0, 33, 2, 33}, zero4, 1'b0, 3'd1);
    run_symbol(2'b00, 1'b1, 1'b0, 3'd2);
    check_frame("s4_first", '{0, 33, 2, 33}, zero4, 1'b0, 3'd2);

    // Scenario 5: 60 random symbols against the trellis model
    model_pm = '{0, 33, 2, 33};
    for (int n = 0; n < 60; n++) begin
      rs  = 2'($urandom_range(0, 3));
      rt  = ($urandom_range(0, 7) == 0);
      rid = 3'($urandom_range(0, 7));
      model_step(rs, rt);
      run_symbol(rs, 1'b0, rt, rid);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd%0d_pm%0d", n, k), got_pm[k], exp_pm[k]);
        chk($sformatf("rnd%0d_dec%0d", n, k), got_dec[k], exp_dec[k]);
      end
      chk($sformatf("rnd%0d_id", n), got_id[0], rid);
      chk($sformatf("rnd%0d_term", n), got_term[3], rt);
    end

    // Scenario 6: sym_valid held high, one accept every 5 cycles
    tags  = '{3'd3, 3'd6, 3'd1, 3'd4};
    n_rec = 0;
    idx   = 0;
    sym_in = 2'b00; sym_first = 1'b0; sym_term = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge PM_clk);
      if (out_valid && addr_out == 2'd0 && n_rec < 8) begin
        rec_id[n_rec]  = data_id_out;
        rec_cyc[n_rec] = cyc;
        n_rec++;
      end
      if (sym_ready) begin
        if (idx < 4) begin
          sym_valid = 1'b1;
          data_id   = tags[idx];
          idx++;
        end else begin
          sym_valid = 1'b0;
        end
      end
    end
    sym_valid = 1'b0;
    chk("tp_count", n_rec, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_rec) chk($sformatf("tp_id%0d", i), rec_id[i], tags[i]);
      else           chk($sformatf("tp_id%0d_missing", i), n_rec, 4);
    end
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < n_rec) chk($sformatf("tp_gap%0d", i), rec_cyc[i+1] - rec_cyc[i], 5);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
